// File: rtl/ahb_req_master.sv
// Single-outstanding AHB-Lite initiator: valid/ready request in, AHB transfer out, valid/ready response back.
// Optional local size/alignment reject path enabled by AHB_REQ_MASTER_ALIGN_CHK_EN.
module ahb_req_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [2:0]            i_req_size,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_hwrite,
  output logic [1:0]            o_htrans,
  output logic [2:0]            o_hsize,
  output logic [ADDR_WIDTH-1:0] o_haddr,
  output logic [DATA_WIDTH-1:0] o_hwdata,
  input  logic                  i_hready,
  input  logic                  i_hresp,
  input  logic [DATA_WIDTH-1:0] i_hrdata
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

  state_t                  state_p0;
  state_t                  state_nxt;
  logic                    req_fire;
  logic                    reject;
  logic                    cmd_write_p0;
  logic [2:0]              cmd_size_p0;
  logic [ADDR_WIDTH-1:0]   cmd_addr_p0;
  logic [DATA_WIDTH-1:0]   cmd_wdata_p0;
  logic                    rsp_err_p1;
  logic [DATA_WIDTH-1:0]   rsp_rdata_p1;

`ifdef AHB_REQ_MASTER_ALIGN_CHK_EN
  function automatic logic bad_align(input logic [2:0] size, input logic [1:0] lsb);
    bad_align = (size > 3'b010) ||
                ((size == 3'b001) && lsb[0]) ||
                ((size == 3'b010) && (lsb != 2'b00));
  endfunction

  assign reject = bad_align(i_req_size, i_req_addr[1:0]);
`else
  assign reject = 1'b0;
`endif

  // Ready is masked during reset so every output reads 0 while i_rst is high.
  assign o_req_ready = (state_p0 == ST_IDLE) && !i_rst;
  assign req_fire    = i_req_valid && o_req_ready;

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      ST_IDLE: if (req_fire)    state_nxt = reject ? ST_RESP : ST_ADDR;
      ST_ADDR: if (i_hready)    state_nxt = ST_DATA;
      ST_DATA: if (i_hready)    state_nxt = ST_RESP;
      ST_RESP: if (i_rsp_ready) state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_p0 <= ST_IDLE;
    else       state_p0 <= state_nxt;
  end

  // Stage p0: request capture; holds address-phase values until the next issued request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cmd_write_p0 <= 1'b0;
      cmd_size_p0  <= 3'b000;
      cmd_addr_p0  <= '0;
      cmd_wdata_p0 <= '0;
    end else if (req_fire && !reject) begin
      cmd_write_p0 <= i_req_write;
      cmd_size_p0  <= i_req_size;
      cmd_addr_p0  <= i_req_addr;
      cmd_wdata_p0 <= i_req_wdata;
    end
  end

  // Stage p1: response capture at the end of the data phase, or on a local reject.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_err_p1   <= 1'b0;
      rsp_rdata_p1 <= '0;
    end else if (req_fire && reject) begin
      rsp_err_p1   <= 1'b1;
      rsp_rdata_p1 <= '0;
    end else if ((state_p0 == ST_DATA) && i_hready) begin
      rsp_err_p1   <= i_hresp;
      rsp_rdata_p1 <= cmd_write_p0 ? '0 : i_hrdata;
    end
  end

  assign o_htrans    = (state_p0 == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign o_haddr     = cmd_addr_p0;
  assign o_hsize     = cmd_size_p0;
  assign o_hwrite    = cmd_write_p0;
  assign o_hwdata    = cmd_wdata_p0;
  assign o_rsp_valid = (state_p0 == ST_RESP);
  assign o_rsp_rdata = rsp_rdata_p1;
  assign o_rsp_err   = rsp_err_p1;

endmodule

// File: tb/tb_ahb_req_master.sv
// Bench for ahb_req_master: table of transfers driven through a scheduled slave, scoreboard on responses.
module tb_ahb_req_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata;
  logic        hready, hresp;
  logic [31:0] hrdata;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef AHB_REQ_MASTER_ALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  ahb_req_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
    .i_req_size(req_size), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_hwrite(hwrite), .o_htrans(htrans), .o_hsize(hsize), .o_haddr(haddr), .o_hwdata(hwdata),
    .i_hready(hready), .i_hresp(hresp), .i_hrdata(hrdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time expired, got running, want finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          aw;         // address-phase wait states
    int          dw;         // data-phase wait states
    logic        slv_err;
    logic [31:0] slv_rdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;    // cycles from accept edge to rsp_valid
    int          hold;       // cycles rsp_ready is held low
    logic        exp_nonseq;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit          seen;
    int          ns_hi;
    int          dk;
    bit          exp_ns;
    logic [31:0] held;
    exp_t        e;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = v.wr; req_size = v.size;
    req_addr = v.addr; req_wdata = v.wdata;
    sb_q.push_back('{v.exp_rdata, v.exp_err});
    hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
    seen = 1'b0; ns_hi = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'($urandom_range(0, 1));
      if (rsp_valid) begin
        seen = 1'b1;
        chk("rsp_latency", 32'(k), 32'(v.exp_lat));
      end else begin
        exp_ns = v.exp_nonseq && (k <= v.aw + 1);
        chk("htrans", 32'(htrans), exp_ns ? 32'h2 : 32'h0);
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (exp_ns) begin
          chk("haddr", haddr, v.addr);
          chk("hsize", 32'(hsize), 32'(v.size));
          chk("hwrite", 32'(hwrite), 32'(v.wr));
          hready = (k == v.aw + 1); hresp = 1'b0; hrdata = $urandom;
        end else begin
          dk = k - (v.aw + 1);
          if (v.exp_nonseq && v.wr) chk("hwdata", hwdata, v.wdata);
          hready = (dk > v.dw);
          hresp  = v.slv_err && (dk >= v.dw);
          hrdata = (dk > v.dw) ? v.slv_rdata : $urandom;
        end
        if (htrans == 2'b10 && hready) ns_hi++;
      end
    end
    rsp_ready = 1'b0;
    hready = 1'b1; hresp = 1'b0;
    if (!seen) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      void'(sb_q.pop_front());
      return;
    end
    e = sb_q.pop_front();
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_err", 32'(rsp_err), 32'(e.err));
    chk("nonseq_count", 32'(ns_hi), v.exp_nonseq ? 32'd1 : 32'd0);
    held = rsp_rdata;
    req_valid = (v.hold > 0);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_rdata", rsp_rdata, held);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_cleared", 32'(rsp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd2, 32'h7A9A_5300, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 3, 0, 1'b1};
    vecs[1] = '{1'b0, 3'd2, 32'h7A9A_5300, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 3, 5, 1'b1};
    vecs[2] = '{1'b1, 3'd2, 32'h1000_0004, 32'h1234_5678, 3, 2, 1'b0, 32'h0, 1'b0, 32'h0, 8, 0, 1'b1};
    vecs[3] = '{1'b0, 3'd2, 32'h1000_0008, 32'h0, 0, 1, 1'b1, 32'hBAD0_BAD0, 1'b1, 32'hBAD0_BAD0, 4, 0, 1'b1};
    vecs[4] = '{1'b1, 3'd2, 32'h1000_000C, 32'hA5A5_0F0F, 1, 1, 1'b1, 32'h0, 1'b1, 32'h0, 5, 1, 1'b1};
    vecs[5] = '{1'b0, 3'd0, 32'h2000_0003, 32'h0, 0, 0, 1'b0, 32'h0000_00A5, 1'b0, 32'h0000_00A5, 3, 0, 1'b1};
    vecs[6] = '{1'b0, 3'd1, 32'h2000_0002, 32'h0, 2, 0, 1'b0, 32'h0000_BEEF, 1'b0, 32'h0000_BEEF, 5, 0, 1'b1};
    vecs[7] = '{1'b1, 3'd2, 32'h7000_0002, 32'h0BAD_CAFE, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0,
                CHK ? 1 : 3, 0, !CHK};
    vecs[8] = '{1'b0, 3'd3, 32'h3000_0000, 32'h0, 0, 0, 1'b0, 32'h1111_2222, CHK,
                CHK ? 32'h0 : 32'h1111_2222, CHK ? 1 : 3, 0, !CHK};
    vecs[9] = '{1'b0, 3'd1, 32'h4000_0001, 32'h0, 0, 0, 1'b0, 32'h0000_7777, CHK,
                CHK ? 32'h0 : 32'h0000_7777, CHK ? 1 : 3, 0, !CHK};
    if (CHK) vecs[7].exp_err = 1'b1;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset asserted while the slave stretches the data phase.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 3'd2;
    req_addr = 32'h55AA_0000; req_wdata = 32'hCAFE_F00D; hready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_seq_nonseq", 32'(htrans), 32'h2);
    @(negedge clk);
    hready = 1'b0;
    @(negedge clk);
    chk("rst_seq_data_idle", 32'(htrans), 32'd0);
    chk("rst_seq_hwdata", hwdata, 32'hCAFE_F00D);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_htrans", 32'(htrans), 32'd0);
    chk("midrst_haddr", haddr, 32'd0);
    chk("midrst_hwdata", hwdata, 32'd0);
    chk("midrst_hwrite", 32'(hwrite), 32'd0);
    chk("midrst_hsize", 32'(hsize), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0; hready = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", 32'(req_ready), 32'd1);
    chk("midrst_release_rsp", 32'(rsp_valid), 32'd0);
    run_vec(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
